shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Iterative radix-2 shift-and-add multiplier producing the low N bits of a*b.
- Sits directly downstream of shift_left_logical: each cycle it consumes the shifter's output (multiplicand << bit index) as the partial product and conditionally accumulates it.
- Target use: multi-cycle MUL unit beside the ALU.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- N, 32, operand and result width. Only 32 is required to work.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  N  multiplicand.
- b  input  N  multiplier.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts product.
- product  output  N  low N bits of a*b.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset (rst high at an edge):
  - state goes to S_IDLE; acc, count, multiplicand and multiplier registers go to 0.
  - After that edge: in_ready=1, out_valid=0, product=0.
  - rst has priority over every other input in every state.
- States: S_IDLE, S_RUN, S_DONE. Outputs are decoded from registered state only; no combinational path from inputs to outputs.
- S_IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge (acceptance edge E0): latch a into mcand and b into mplier, clear acc and count, go to S_RUN.
  - No in_valid: stay in S_IDLE.
- S_RUN:
  - in_ready=0, out_valid=0.
  - shift_left_logical is driven with in=mcand and shamt=count.
  - At each edge: if mplier[count]=1, acc <= acc + shifter_out (mod 2^N); otherwise acc is unchanged. count <= count+1.
  - When count==N-1 at an edge, that bit is processed and the state goes to S_DONE.
  - RUN lasts exactly N cycles; there is no early termination, so latency is fixed.
- S_DONE:
  - out_valid=1, in_ready=0.
  - product holds acc, stable until the handshake.
  - On out_ready at an edge, go to S_IDLE; acc is kept but is not valid.
  - Without out_ready, stay in S_DONE indefinitely.
- Latency: out_valid is first high after edge E0+N, i.e. N cycles after acceptance. Minimum initiation interval is N+2 cycles.
- Ignored inputs:
  - in_valid, a and b are ignored outside S_IDLE.
  - Operand changes after E0 have no effect.
  - out_ready is ignored outside S_DONE.
- Arithmetic and width rules:
  - All additions wrap mod 2^N; the carry out is discarded.
  - The result equals the low N bits for both signed and unsigned interpretations (RV32 MUL semantics).
  - count is $clog2(N) bits wide and matches the shifter's shamt width; the terminal compare is against N-1.
- product outside S_DONE is unspecified by contract. The implementation drives acc, and the bench checks product only when out_valid=1.
- Reset mid-operation (in S_RUN or S_DONE): the result is abandoned with no out_valid pulse, and the block is back in S_IDLE after the reset edge.
- Illegal state encoding: the default branch goes to S_IDLE.

Decomposition:
- Shared package mul_pkg:
  - typedef enum logic [1:0] mul_state_t {S_IDLE, S_RUN, S_DONE}.
  - localparam MUL_LATENCY = N.
- One sub-module: the existing shift_left_logical (N=32), instantiated once for the partial product.
- The adder is a plain expression; no ripple-adder instance is required.

Test Plan:
1. Reset then basic: rst 2 cycles, then a=3, b=5, in_valid 1 cycle -> out_valid rises exactly 32 cycles after acceptance, product=15. After out_ready, in_ready=1 next cycle.
2. Wrap/signed: a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0x00000001. Also a=0x80000000, b=2 -> product=0x00000000.
3. Carry discard: a=0x00010001, b=0x00010001 -> product=0x00020001. Also a=0, b=0xDEADBEEF -> 0.
4. Backpressure: hold out_ready=0 for 5 cycles in S_DONE with in_valid=1 and new operands presented -> product stays constant, in_ready=0, new operands ignored. out_ready=1 -> IDLE, then a second op 7*6 yields 42.
5. Reset mid-run: accept 0x1234*0x10, assert rst on RUN cycle 10 -> next cycle in_ready=1, out_valid=0, and no out_valid ever appears for that op. A subsequent 9*9 gives 81.
6. Randomized sweep: 200 random a/b pairs with random out_ready stalls -> every product equals (a*b) mod 2^32. Exactly one out_valid handshake per accepted operand pair.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative shift-and-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_W       = 32;
    localparam int unsigned MUL_LATENCY = MUL_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result valid-ready bus of the multiplier.
interface shift_add_multiplier_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_left_logical.sv
// Logical left shift; supplies the partial product mcand << bit index.
module shift_left_logical #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0]         in,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         out
);
    assign out = in << shamt;
endmodule

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add multiplier, low N bits of a*b, fixed N-cycle latency.
module shift_add_multiplier
    import mul_pkg::*;
#(
    parameter int unsigned N = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    mul_state_t    state, state_d;
    logic [N-1:0]  acc, acc_d;
    logic [N-1:0]  mcand, mcand_d;
    logic [N-1:0]  mplier, mplier_d;
    logic [CW-1:0] count, count_d;
    logic [N-1:0]  partial;
    logic          in_ready_q;
    logic          out_valid_q;

    shift_left_logical #(.N(N)) u_shift (
        .in    (mcand),
        .shamt (count),
        .out   (partial)
    );

    // State and datapath registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            mcand       <= mcand_d;
            mplier      <= mplier_d;
            count       <= count_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        count_d  = count;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Every bit is visited; no early exit keeps the latency fixed.
                if (mplier[count]) begin
                    acc_d = N'(acc + partial);
                end
                count_d = CW'(count + CW'(1));
                if (count == CW'(N - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: directed corners plus random sweep.
module tb_shift_add_multiplier;
    import mul_pkg::*;

    localparam int unsigned N = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_add_multiplier_if #(.N(N)) bus ();

    shift_add_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] sb[$];
    int n_checks    = 0;
    int n_fail      = 0;
    int n_accept    = 0;
    int n_handshake = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for in_ready, present one operand pair for one cycle, record expectation.
    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] exp);
        int w = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: in_ready=%0b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        sb.push_back(exp);
        n_accept++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
    endtask

    // Called on the negedge right after acceptance; checks latency, result, stall hold, handshake.
    task automatic recv(input int stall);
        int           lat = 0;
        logic [N-1:0] exp;
        logic [N-1:0] held;
        n_checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_flags: in_ready=%0b out_valid=%0b required 0 0", bus.in_ready, bus.out_valid);
        end
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != int'(MUL_LATENCY)) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles required %0d", lat, MUL_LATENCY);
        end
        if (bus.out_valid !== 1'b1) return;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: product=%h with no pending expectation", bus.product);
            exp = 'x;
        end else begin
            exp = sb.pop_front();
        end
        n_checks++;
        if (bus.product !== exp) begin
            n_fail++;
            $display("FAIL product: got %h required %h", bus.product, exp);
        end
        held = bus.product;
        repeat (stall) begin
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== held) begin
                n_fail++;
                $display("FAIL stall_hold: out_valid=%0b in_ready=%0b product=%h required 1 0 %h",
                         bus.out_valid, bus.in_ready, bus.product, held);
            end
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_handshake++;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_handshake: out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.product !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b product=%h required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.product);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        send(32'd3, 32'd5, 32'd15);
        recv(0);
    endtask

    task automatic test_wrap();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        recv(1);
        send(32'h8000_0000, 32'd2, 32'h0000_0000);
        recv(0);
    endtask

    task automatic test_carry();
        send(32'h0001_0001, 32'h0001_0001, 32'h0002_0001);
        recv(2);
        send(32'h0, 32'hDEAD_BEEF, 32'h0);
        recv(0);
    endtask

    task automatic test_backpressure();
        int           w = 0;
        logic [N-1:0] held;
        logic [N-1:0] exp;
        send(32'h0000_1111, 32'h0000_0003, 32'h0000_3333);
        while (bus.out_valid !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        exp = (sb.size() != 0) ? sb.pop_front() : 'x;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== exp) begin
            n_fail++;
            $display("FAIL bp_result: out_valid=%0b product=%h required 1 %h", bus.out_valid, bus.product, exp);
        end
        held = bus.product;
        bus.in_valid = 1'b1;
        repeat (5) begin
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.product !== held) begin
                n_fail++;
                $display("FAIL bp_hold: out_valid=%0b in_ready=%0b product=%h required 1 0 %h",
                         bus.out_valid, bus.in_ready, bus.product, held);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_handshake++;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
        end
        send(32'd7, 32'd6, 32'd42);
        recv(0);
    endtask

    task automatic test_reset_midrun();
        int seen = 0;
        send(32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        n_accept--;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: in_ready=%0b out_valid=%0b required 1 0", bus.in_ready, bus.out_valid);
        end
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abandoned_valid: out_valid seen %0d cycles required 0", seen);
        end
        send(32'd9, 32'd9, 32'd81);
        recv(0);
    endtask

    task automatic test_random_sweep();
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] p;
        for (int i = 0; i < 200; i++) begin
            x = $urandom;
            y = $urandom;
            if (i % 16 == 0) y = '0;
            if (i % 16 == 1) x = '1;
            p = x * y;
            send(x, y, p);
            recv(int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_carry();
        test_backpressure();
        test_reset_midrun();
        test_random_sweep();
        n_checks++;
        if (n_accept != n_handshake || sb.size() != 0) begin
            n_fail++;
            $display("FAIL handshake_count: accepted=%0d handshakes=%0d pending=%0d required equal and 0 pending",
                     n_accept, n_handshake, sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
